// File: rtl/lpf_channel_scheduler.sv
// Shared one-pole low-pass datapath (y += ((x - y) * alpha) >>> 8), time-multiplexed
// across NCH channels with per-channel state, gliding alpha and a valid/ready input.
module lpf_channel_scheduler #(
  parameter int BITSIZE   = 16,
  parameter int NCH       = 4,
  parameter int RAMP_STEP = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [$clog2(NCH)-1:0]     in_ch,
  input  logic signed [BITSIZE-1:0]  in_data,
  input  logic                       cfg_we,
  input  logic                       cfg_clr,
  input  logic [$clog2(NCH)-1:0]     cfg_ch,
  input  logic [7:0]                 cfg_alpha,
  output logic                       out_valid,
  output logic [$clog2(NCH)-1:0]     out_ch,
  output logic signed [BITSIZE-1:0]  out_data,
  output logic                       busy
);

  localparam int CW = $clog2(NCH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] MULT  = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  localparam logic [7:0] STEP = 8'(RAMP_STEP);

  logic [1:0]                state;
  logic [CW-1:0]             ch_r;
  logic signed [BITSIZE-1:0] x_r;
  logic signed [BITSIZE-1:0] yr;
  logic [7:0]                ar;
  logic signed [BITSIZE:0]   d_r;
  logic signed [BITSIZE:0]   p_r;

  logic signed [BITSIZE-1:0] y_mem     [NCH];
  logic [7:0]                alpha_cur [NCH];
  logic [7:0]                alpha_tgt [NCH];

  logic signed [BITSIZE-1:0] y_sel;
  logic signed [BITSIZE:0]   d_next;
  logic signed [BITSIZE+9:0] d_ext;
  logic signed [BITSIZE+9:0] a_ext;
  logic signed [BITSIZE+9:0] prod;
  logic signed [BITSIZE:0]   p_next;
  logic signed [BITSIZE-1:0] ynew;
  logic [7:0]                cur_sel;
  logic [7:0]                tgt_eff;
  logic [7:0]                alpha_next;

  assign in_ready = (state == IDLE);
  assign busy     = !in_ready;

  always_comb begin
    y_sel  = y_mem[ch_r];
    d_next = {x_r[BITSIZE-1], x_r} - {y_sel[BITSIZE-1], y_sel};
    // Operands widened to the full product width so the truncated product is exact.
    d_ext  = {{9{d_r[BITSIZE]}}, d_r};
    a_ext  = {{(BITSIZE+2){1'b0}}, ar};
    prod   = d_ext * a_ext;
    p_next = (BITSIZE+1)'(prod >>> 8);
    ynew   = BITSIZE'(p_r + {yr[BITSIZE-1], yr});
  end

  // A target written during the WRITE cycle already steers this sample's ramp step.
  always_comb begin
    cur_sel    = alpha_cur[ch_r];
    tgt_eff    = (cfg_we && (cfg_ch == ch_r)) ? cfg_alpha : alpha_tgt[ch_r];
    alpha_next = cur_sel;
    if (cur_sel < tgt_eff) begin
      alpha_next = ((tgt_eff - cur_sel) > STEP) ? (cur_sel + STEP) : tgt_eff;
    end else if (cur_sel > tgt_eff) begin
      alpha_next = ((cur_sel - tgt_eff) > STEP) ? (cur_sel - STEP) : tgt_eff;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      ch_r      <= '0;
      x_r       <= '0;
      yr        <= '0;
      ar        <= '0;
      d_r       <= '0;
      p_r       <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            ch_r  <= in_ch;
            x_r   <= in_data;
            state <= FETCH;
          end
        end
        FETCH: begin
          yr    <= y_sel;
          ar    <= alpha_cur[ch_r];
          d_r   <= d_next;
          state <= MULT;
        end
        MULT: begin
          p_r   <= p_next;
          state <= WRITE;
        end
        WRITE: begin
          out_valid <= 1'b1;
          out_ch    <= ch_r;
          out_data  <= ynew;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A clear on the channel being written back takes priority over the new value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        y_mem[i]     <= '0;
        alpha_cur[i] <= '0;
        alpha_tgt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (cfg_clr && (cfg_ch == CW'(i))) begin
          y_mem[i] <= '0;
        end else if ((state == WRITE) && (ch_r == CW'(i))) begin
          y_mem[i] <= ynew;
        end
        if ((state == WRITE) && (ch_r == CW'(i))) begin
          alpha_cur[i] <= alpha_next;
        end
        if (cfg_we && (cfg_ch == CW'(i))) begin
          alpha_tgt[i] <= cfg_alpha;
        end
      end
    end
  end

endmodule

// File: tb/tb_lpf_channel_scheduler.sv
// Scoreboard bench for lpf_channel_scheduler: directed samples with hand-computed
// filter outputs, checked by an independent monitor on every out_valid pulse.
module tb_lpf_channel_scheduler;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_ch = '0;
  logic signed [15:0] in_data = '0;
  logic              cfg_we = 1'b0;
  logic              cfg_clr = 1'b0;
  logic [1:0]        cfg_ch = '0;
  logic [7:0]        cfg_alpha = '0;
  logic              out_valid;
  logic [1:0]        out_ch;
  logic signed [15:0] out_data;
  logic              busy;

  lpf_channel_scheduler #(
    .BITSIZE(16),
    .NCH(4),
    .RAMP_STEP(4)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_ch(in_ch),
    .in_data(in_data),
    .cfg_we(cfg_we),
    .cfg_clr(cfg_clr),
    .cfg_ch(cfg_ch),
    .cfg_alpha(cfg_alpha),
    .out_valid(out_valid),
    .out_ch(out_ch),
    .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]         ch;
    logic signed [15:0] data;
    int                 acc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int outs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetn && out_valid) begin
      checks++;
      outs++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got ch=%0d data=%0d, required no output", out_ch, out_data);
      end else begin
        e = sb.pop_front();
        if (out_ch !== e.ch || out_data !== e.data || (cyc - e.acc) != 3) begin
          fails++;
          $display("FAIL out_sample: got ch=%0d data=%0d lat=%0d, required ch=%0d data=%0d lat=3",
                   out_ch, out_data, cyc - e.acc, e.ch, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic push_exp(input int c, input int y);
    exp_t e;
    e.ch   = 2'(c);
    e.data = 16'(y);
    e.acc  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("FAIL ready_timeout: got in_ready=0, required 1");
    end
  endtask

  task automatic send(input int c, input int x, input int y_exp);
    @(negedge clk);
    wait_ready();
    in_valid = 1'b1;
    in_ch    = 2'(c);
    in_data  = 16'(x);
    push_exp(c, y_exp);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic cfg(input int c, input int a);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_ch    = 2'(c);
    cfg_alpha = 8'(a);
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin : stim
    int bx[4];
    int by[4];
    int low;
    int n;
    int outs0;
    bx = '{1750, 255, 373, 5000};
    by = '{1250, 127, 127, 0};

    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_out_data", int'(out_data), 0);
    resetn = 1'b1;

    // Glide ch0/ch1 alpha to 128 with zero input: y stays 0 throughout.
    cfg(0, 128);
    cfg(1, 128);
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      send(0, 0, 0);
      send(1, 0, 0);
    end
    drain();

    send(0, 1000, 500);
    send(0, 1000, 750);
    send(1, -1000, -500);
    send(1, -1000, -750);
    drain();

    // Clear ch1 while idle, then check floor rounding around zero.
    @(negedge clk);
    cfg_clr = 1'b1;
    cfg_ch  = 2'd1;
    @(negedge clk);
    cfg_clr = 1'b0;
    send(1, -1, -1);
    send(1, -1, -1);
    send(1, 0, -1);
    drain();

    // Ramp target 10 from 0, step 4: alphas used 0, 4, 8, 10, 10.
    cfg(2, 10);
    send(2, 1000, 0);
    send(2, 1000, 15);
    send(2, 1000, 45);
    send(2, 1000, 82);
    send(2, 1000, 117);
    drain();

    // Back-to-back: in_valid held high across all four channels.
    low = 0;
    outs0 = outs;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
        low++;
        @(negedge clk);
        n++;
      end
      in_valid = 1'b1;
      in_ch    = 2'(k);
      in_data  = 16'(bx[k]);
      push_exp(k, by[k]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    chk("burst_ready_low_cycles", low, 9);
    chk("burst_pulses", outs - outs0, 4);

    // Clear ch0 in the WRITE cycle of its own op.
    @(negedge clk);
    wait_ready();
    in_valid = 1'b1;
    in_ch    = 2'd0;
    in_data  = 16'sd2250;
    push_exp(0, 1750);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("clr_write_busy", int'(busy), 1);
    cfg_clr = 1'b1;
    cfg_ch  = 2'd0;
    @(negedge clk);
    cfg_clr = 1'b0;
    send(0, 1000, 500);
    drain();

    // Reset during MULT: op aborted, all state cleared.
    @(negedge clk);
    wait_ready();
    in_valid = 1'b1;
    in_ch    = 2'd0;
    in_data  = 16'sd3000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    chk("post_rst_in_ready", int'(in_ready), 1);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_out_valid", int'(out_valid), 0);
    chk("post_rst_out_data", int'(out_data), 0);
    repeat (6) @(negedge clk);
    send(0, 1234, 0);
    send(1, -77, 0);
    send(2, 900, 0);
    drain();

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/lpf_channel_scheduler.md
Name: lpf_channel_scheduler

Overview:
Time-multiplexes one shared one-pole low-pass datapath, y += ((x − y)·alpha) >>> 8, across NCH independent audio channels.
- Per-channel state (y) and coefficient (alpha) are held in internal register files.
- Requesters submit samples through a valid/ready handshake. The block sequences fetch, multiply and writeback.
- Each channel's alpha glides toward a configured target by a fixed step per processed sample, so cutoff changes do not produce zipper noise.
- Sits between the audio sample sources (codec/oscillators) and the mixer.

Parameters:
BITSIZE, 16, signed sample width
NCH, 4, number of channels (power of 2, ≥2)
RAMP_STEP, 4, alpha increment/decrement per processed sample (1..255)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
in_valid  in  1  sample request valid
in_ready  out  1  block can accept request
in_ch  in  log2(NCH)  channel of request
in_data  in  BITSIZE  signed unfiltered sample
cfg_we  in  1  write alpha target for cfg_ch
cfg_clr  in  1  zero filter state y of cfg_ch
cfg_ch  in  log2(NCH)  config channel
cfg_alpha  in  8  unsigned alpha target (0..255; output gain per step alpha/256)
out_valid  out  1  one-cycle result strobe
out_ch  out  log2(NCH)  channel of result
out_data  out  BITSIZE  signed filtered sample
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, resetn=0): FSM→IDLE, all y[i]=0, alpha_cur[i]=alpha_tgt[i]=0, out_valid=0, out_ch=0, out_data=0, in_ready=1, busy=0. Reset asserted mid-operation aborts the op with no writeback and no out_valid.
- FSM: IDLE → FETCH → MULT → WRITE → IDLE.
- in_ready = (state==IDLE). busy = !in_ready.
- Handshake: accept when in_valid && in_ready. Latch ch/data at the accept edge. in_valid held while !in_ready is not consumed.
- FETCH: latch yr=y[ch] and ar=alpha_cur[ch]. Compute d = x − yr, signed BITSIZE+1.
- MULT: p = (d × {1'b0,ar}) >>> 8, arithmetic shift (floor), kept BITSIZE+1 bits.
- WRITE:
  - ynew = yr + p, truncated to BITSIZE. This is provably in range: |p| ≤ |d| because ar < 256.
  - y[ch]=ynew.
  - out_valid=1, out_ch=ch, out_data=ynew.
  - Ramp: alpha_cur[ch] moves toward alpha_tgt[ch] by RAMP_STEP, clamped so it never overshoots the target.
- Latency: accept at edge 0 → out_valid high for the cycle after edge 3. Throughput 1 sample / 4 cycles.
- out_data and out_ch hold their value until the next WRITE. out_valid is a single-cycle pulse.
- The alpha used for a sample is alpha_cur before that sample's ramp step. alpha=0 freezes y; alpha=255 is near-bypass.
- cfg_we: any cycle, alpha_tgt[cfg_ch]=cfg_alpha. An op in flight on the same channel keeps the ar latched in FETCH. The new target affects that op's ramp step only if written before or in the WRITE cycle.
- cfg_clr: y[cfg_ch]=0 next edge.
  - If cfg_clr coincides with WRITE for the same channel, the clear wins: stored y=0, out_data still equals the computed ynew.
  - If cfg_clr targets the channel during FETCH/MULT, the in-flight op still uses yr latched in FETCH.
- cfg_we and cfg_clr in the same cycle: both take effect.

Test Plan:
- Reset, cfg_we ch0 alpha 128, wait ≥1 cycle. Then use RAMP_STEP=128 or preload alpha_cur=128 via repeated samples. Send ch0 x=1000 twice → out_data 500, then 750. out_valid 4 cycles after each accept.
- With alpha_cur=128, ch1 x=−1000 from y=0 → out_data −500. Next x=−1000 → −750 (floor rounding checked at odd values: x=−1 → 0 − 1·128>>>8 = −1).
- Ramp, RAMP_STEP=4: target 10 from 0. Successive ch2 samples use alpha 0, 4, 8, 10, 10. The first sample outputs unchanged y=0.
- Back-to-back in_valid held high on ch0..ch3 → in_ready low 3 of every 4 cycles. Exactly 4 out_valid pulses, correct out_ch order, no state cross-talk between channels.
- cfg_clr ch0 in the WRITE cycle of a ch0 op → out_data = computed value, next ch0 sample filters from y=0.
- Assert resetn during MULT → no out_valid, all y=0, in_ready=1 immediately after release.
